barrel_shifter_sweeper: RTL and testbench
=========================================

# barrel_shifter_sweeper

Self-checking stimulus engine for the 4-bit barrel shifter (`barrel_shifter_4bit`). It drives the shifter's `data_in`/`shift_amt`/`dir`/`mode` inputs, samples `data_out`, and compares it against an internal golden model. On a `start` pulse it sweeps every legal operand combination, one vector per clock. It is the in-fabric counterpart to the simulation bench and is used for on-board self-test of the shifter.

## Interface
- `ERR_W`, default 8: width of the saturating error counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock domain; asynchronous, active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `data_out`  in  4  result returned by the shifter under test.
- `data_in`  out  4  operand driven to the shifter; registered.
- `shift_amt`  out  2  shift amount driven to the shifter; registered.
- `dir`  out  1  direction: 0 = left, 1 = right; registered.
- `mode`  out  2  operation: 00 = logical, 01 = rotate, 10 = arithmetic; registered.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; held until the next `start` or reset.
- `pass`  out  1  high with `done` when `err_count` == 0.
- `err_count`  out  ERR_W  mismatches seen; saturates at 2^ERR_W−1.
- `first_fail`  out  9  vector index of the first mismatch.
- `fail_seen`  out  1  at least one mismatch in this sweep.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after index 383 is checked.
  - DONE → RUN on `start`.
  - `start` in RUN is ignored.
- Entering RUN clears `err_count`, `first_fail`, `fail_seen`, `pass` and `done`, and sets the index to 0.
- Vector index v is 9 bits: v = mode·128 + dir·64 + shift_amt·16 + data_in.
  - `data_in` varies fastest, then `shift_amt`, then `dir`; `mode` is outermost.
  - Legal range is 0..383, i.e. 384 vectors. Mode 11 is never driven.
- Golden model, with d = `data_in` and a = `shift_amt`, all results 4 bits:
  - mode 00, dir 0: (d << a) truncated to 4 bits.
  - mode 00, dir 1: d >> a, zero fill.
  - mode 01, dir 0: rotate d left by a.
  - mode 01, dir 1: rotate d right by a.
  - mode 10, dir 1: d >> a, filled with d[3].
  - mode 10, dir 0: same as logical left.
- On a mismatch:
  - `err_count` increments, saturating.
  - If `fail_seen` == 0, `first_fail` ← v and `fail_seen` ← 1.
- Reset values: all outputs 0; state IDLE; index 0.
- Asynchronous reset mid-sweep aborts immediately: all outputs return to 0 and the state returns to IDLE. The shifter inputs are driven to 0000/00/0/00.

## Timing
- Edge E0 samples `start` high. After E0: `busy` = 1 and vector 0 is on the outputs.
- Vector k is held for exactly one cycle, from edge Ek to edge Ek+1.
- The shifter is combinational. At edge Ek+1 the checker samples `data_out`, compares it against golden(vector k), and advances to vector k+1 on the same edge.
- Edge E384 checks vector 383. After E384: `busy` = 0, `done` = 1, `pass` = (`err_count` == 0).
- `busy` is high for exactly 384 cycles.
- In DONE the outputs hold vector 383 unchanged.
- `err_count`, `first_fail` and `fail_seen` are stable from `done` onward.
- Restart is allowed in the cycle `done` is high. It costs no idle cycle, so the next sweep's vector 0 appears after that edge.

## Test plan
- **Ideal shifter, `start` pulse:** `busy` high for 384 cycles, then `done` = 1, `pass` = 1, `err_count` = 0, `fail_seen` = 0.
- **Vector order:** at busy cycle 17 the outputs are `data_in` = 0001, `shift_amt` = 01, `dir` = 0, `mode` = 00. At busy cycle 344 the outputs are `data_in` = 1000, `shift_amt` = 01, `dir` = 1, `mode` = 10; an ideal shifter returns 1100 there.
- **Shifter fault, ASR implemented as LSR:** `err_count` = 24, `first_fail` = 344, `pass` = 0.
- **Shifter output inverted:** `err_count` = 255 (saturated), `first_fail` = 0, `fail_seen` = 1.
- **`start` re-asserted in busy cycle 50:** ignored; `done` still rises after exactly 384 busy cycles.
- **`rst_n` low in busy cycle 100:**
  - All outputs are 0 immediately.
  - After release, `start` runs a clean full sweep to `pass` = 1.
  - A `start` issued while `done` is held restarts with `err_count` cleared.

Source files
------------

// File: rtl/barrel_shifter_sweeper_if.sv
//==============================================================================
// Module   : barrel_shifter_sweeper_if
// Brief    : Control/status and shifter-drive bundle for the shifter sweeper.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface barrel_shifter_sweeper_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic [3:0]       data_out;
    logic [3:0]       data_in;
    logic [1:0]       shift_amt;
    logic             dir;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [8:0]       first_fail;
    logic             fail_seen;

    modport master (
        input  start, data_out,
        output data_in, shift_amt, dir, mode,
        output busy, done, pass, err_count, first_fail, fail_seen
    );

    modport slave (
        output start, data_out,
        input  data_in, shift_amt, dir, mode,
        input  busy, done, pass, err_count, first_fail, fail_seen
    );
endinterface

`default_nettype wire

// File: rtl/barrel_shifter_sweeper.sv
//==============================================================================
// Module   : barrel_shifter_sweeper
// Brief    : Sweeps all 384 legal vectors into a 4-bit barrel shifter and
//            checks each result against a golden model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module barrel_shifter_sweeper #(
    parameter int ERR_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    barrel_shifter_sweeper_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0]       c_LAST_IDX = 9'd383;
    localparam logic [ERR_W-1:0] c_ERR_MAX  = '1;

    state_t           r_state, w_state_next;
    logic [8:0]       r_idx, w_idx_next;
    logic [ERR_W-1:0] r_err, w_err_next;
    logic [8:0]       r_first, w_first_next;
    logic             r_seen, w_seen_next;
    logic             r_done, w_done_next;
    logic             r_pass, w_pass_next;

    logic [3:0] w_d;
    logic [1:0] w_amt;
    logic       w_dir;
    logic [1:0] w_mode;
    logic [7:0] w_rotl;
    logic [7:0] w_rotr;
    logic [3:0] w_golden;
    logic       w_mismatch;

    // The vector index bit fields are the shifter operands directly.
    assign w_d    = r_idx[3:0];
    assign w_amt  = r_idx[5:4];
    assign w_dir  = r_idx[6];
    assign w_mode = r_idx[8:7];

    assign w_rotl = {w_d, w_d} << w_amt;
    assign w_rotr = {w_d, w_d} >> w_amt;

    always_comb begin
        w_golden = 4'b0000;
        case ({w_mode, w_dir})
            3'b000, 3'b100: w_golden = w_d << w_amt;
            3'b001:         w_golden = w_d >> w_amt;
            3'b010:         w_golden = w_rotl[7:4];
            3'b011:         w_golden = w_rotr[3:0];
            3'b101:         w_golden = $signed(w_d) >>> w_amt;
            default:        w_golden = 4'b0000;
        endcase
    end

    assign w_mismatch = (bus.data_out != w_golden);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = r_err;
        w_first_next = r_first;
        w_seen_next  = r_seen;
        w_done_next  = r_done;
        w_pass_next  = r_pass;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_idx_next   = 9'd0;
                    w_err_next   = '0;
                    w_first_next = 9'd0;
                    w_seen_next  = 1'b0;
                    w_done_next  = 1'b0;
                    w_pass_next  = 1'b0;
                end
            end
            RUN: begin
                if (w_mismatch) begin
                    if (r_err != c_ERR_MAX) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (!r_seen) begin
                        w_first_next = r_idx;
                        w_seen_next  = 1'b1;
                    end
                end
                // Final vector: index stays put so the outputs hold vector 383.
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                    w_pass_next  = (r_err == '0) && !w_mismatch;
                end else begin
                    w_idx_next = r_idx + 9'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 9'd0;
            r_err   <= '0;
            r_first <= 9'd0;
            r_seen  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_err   <= w_err_next;
            r_first <= w_first_next;
            r_seen  <= w_seen_next;
            r_done  <= w_done_next;
            r_pass  <= w_pass_next;
        end
    end

    assign bus.data_in    = w_d;
    assign bus.shift_amt  = w_amt;
    assign bus.dir        = w_dir;
    assign bus.mode       = w_mode;
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.first_fail = r_first;
    assign bus.fail_seen  = r_seen;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_sweeper.sv
//==============================================================================
// Module   : tb_barrel_shifter_sweeper
// Brief    : Scoreboard bench for barrel_shifter_sweeper with a fault-injecting
//            shifter stand-in.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_barrel_shifter_sweeper;

    localparam int c_ERR_MAX = 255;

    typedef struct {
        int err;
        int first;
        int seen;
        int pass;
    } status_t;

    logic clk;
    logic rst_n;
    int   fault;
    int   rand_idx;
    int   n_checks;
    int   n_fail;
    int   busy_cnt;
    logic done_prev;
    int   vec_q[$];
    status_t st_q[$];
    int      mon_k;
    status_t mon_s;

    barrel_shifter_sweeper_if #(.ERR_W(8)) bus ();

    barrel_shifter_sweeper #(.ERR_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ideal(int d, int a, int dr, int m);
        int p;
        p = 1 << a;
        if (m == 1 && dr == 0) return ((d * p) % 16) + ((d * p) / 16);
        if (m == 1 && dr == 1) return ideal(d, (4 - a) % 4, 0, 1);
        if (m == 2 && dr == 1) return (d / p) + ((d >= 8) ? (16 - 16 / p) : 0);
        if (dr == 0) return (d * p) % 16;
        return d / p;
    endfunction

    // Shifter under test: ideal, or with one of several injected faults.
    function automatic int shifter(int f, int r, int d, int a, int dr, int m);
        int g;
        int v;
        g = ideal(d, a, dr, m);
        v = m * 128 + dr * 64 + a * 16 + d;
        case (f)
            1: if (m == 2 && dr == 1) g = d / (1 << a);
            2: g = 15 - g;
            3: if (v == r) g = g ^ 1;
            default: ;
        endcase
        return g;
    endfunction

    always_comb begin
        bus.data_out = 4'(shifter(fault, rand_idx, int'(bus.data_in), int'(bus.shift_amt),
                                  int'(bus.dir), int'(bus.mode)));
    end

    function automatic status_t model(int f, int r);
        status_t s;
        int d, a, dr, m;
        s.err = 0; s.first = 0; s.seen = 0; s.pass = 0;
        for (int v = 0; v < 384; v++) begin
            d = v % 16; a = (v / 16) % 4; dr = (v / 64) % 2; m = v / 128;
            if (shifter(f, r, d, a, dr, m) != ideal(d, a, dr, m)) begin
                if (s.seen == 0) begin
                    s.first = v;
                    s.seen  = 1;
                end
                if (s.err < c_ERR_MAX) s.err++;
            end
        end
        s.pass = (s.err == 0) ? 1 : 0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_in"},    32'(bus.data_in),    0);
        check({tag, "_shift_amt"},  32'(bus.shift_amt),  0);
        check({tag, "_dir"},        32'(bus.dir),        0);
        check({tag, "_mode"},       32'(bus.mode),       0);
        check({tag, "_busy"},       32'(bus.busy),       0);
        check({tag, "_done"},       32'(bus.done),       0);
        check({tag, "_pass"},       32'(bus.pass),       0);
        check({tag, "_err_count"},  32'(bus.err_count),  0);
        check({tag, "_first_fail"}, 32'(bus.first_fail), 0);
        check({tag, "_fail_seen"},  32'(bus.fail_seen),  0);
    endtask

    // Monitor: pops an expected vector every busy cycle, a status on done rise.
    always @(negedge clk) begin
        if (bus.busy) begin
            if (vec_q.size() == 0) begin
                check("vec_queue_empty", 1, 0);
            end else begin
                mon_k = vec_q.pop_front();
                check("data_in",   32'(bus.data_in),   mon_k % 16);
                check("shift_amt", 32'(bus.shift_amt), (mon_k / 16) % 4);
                check("dir",       32'(bus.dir),       (mon_k / 64) % 2);
                check("mode",      32'(bus.mode),      mon_k / 128);
            end
            if (busy_cnt == 17) begin
                check("cyc17_vector", {bus.mode, bus.dir, bus.shift_amt, bus.data_in},
                      {2'b00, 1'b0, 2'b01, 4'b0001});
            end
            if (busy_cnt == 344) begin
                check("cyc344_vector", {bus.mode, bus.dir, bus.shift_amt, bus.data_in},
                      {2'b10, 1'b1, 2'b01, 4'b1000});
            end
            busy_cnt++;
        end
        if (bus.done && !done_prev) begin
            check("busy_cycles", busy_cnt, 384);
            busy_cnt = 0;
            if (st_q.size() == 0) begin
                check("status_queue_empty", 1, 0);
            end else begin
                mon_s = st_q.pop_front();
                check("err_count",  32'(bus.err_count),  mon_s.err);
                check("first_fail", 32'(bus.first_fail), mon_s.first);
                check("fail_seen",  32'(bus.fail_seen),  mon_s.seen);
                check("pass",       32'(bus.pass),       mon_s.pass);
            end
        end
        done_prev = bus.done;
    end

    // Called #1 after a rising edge with the DUT in IDLE or DONE.
    task automatic start_sweep(input int f, input int r);
        fault     = f;
        rand_idx  = r;
        bus.start = 1'b1;
        for (int k = 0; k < 384; k++) vec_q.push_back(k);
        st_q.push_back(model(f, r));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_timeout", 32'(ok), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        busy_cnt  = 0;
        done_prev = 1'b0;
        fault     = 0;
        rand_idx  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Ideal sweep; a start pulse in busy cycle 50 must be ignored.
        start_sweep(0, 0);
        repeat (50) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        start_sweep(1, 0);
        wait_done();
        start_sweep(2, 0);
        wait_done();
        start_sweep(0, 0);
        wait_done();

        // Abort in busy cycle 100.
        start_sweep(0, 0);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        vec_q.delete();
        st_q.delete();
        busy_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start_sweep(0, 0);
        wait_done();

        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            start_sweep(3, int'($urandom_range(0, 383)));
            wait_done();
        end
        start_sweep(2, 0);
        wait_done();

        @(negedge clk); #1;
        check("vec_queue_drained", vec_q.size(), 0);
        check("status_queue_drained", st_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
